// File: rtl/coin_collector.sv
// coin_collector: coin/credit front end for the vend core. Collects coins,
// latches a product selection, holds money/prod for the vend core, then pays
// out change (rem) or a full refund on vend failure or cancel.
// Ports: clk, rst (sync, active-high); coin_valid/coin_type, sel_valid/
// sel_prod, cancel from the customer; sold/rem from the vend core; money/prod
// to the vend core; credit, coin_reject, refund_valid/refund_amt, busy.
// Optional macro IDLE_TIMEOUT_EN: auto-refund after IDLE_TIMEOUT idle cycles
// in COLLECT.
module coin_collector #(
    parameter int MAX_CREDIT   = 100,
    parameter int VEND_WAIT    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [2:0] sel_prod,
    input  logic       cancel,
    input  logic       sold,
    input  logic [6:0] rem,
    output logic [6:0] money,
    output logic [2:0] prod,
    output logic [6:0] credit,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [6:0] refund_amt,
    output logic       busy
);

    localparam int WW = (VEND_WAIT > 1) ? $clog2(VEND_WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_REFUND
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    credit_q, credit_d;
    logic [2:0]    prod_q, prod_d;
    logic [6:0]    amt_q, amt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rej_q, rej_d;

    logic [6:0] coin_val;
    logic [7:0] sum;
    logic       coin_ok;
    logic [6:0] credit_add;

`ifdef IDLE_TIMEOUT_EN
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    logic [IW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        unique case (coin_type)
            2'b00:   coin_val = 7'd5;
            2'b01:   coin_val = 7'd10;
            2'b10:   coin_val = 7'd20;
            default: coin_val = 7'd50;
        endcase
    end

    // Sum is one bit wider so an overflowing coin is refused, never wrapped.
    assign sum        = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok    = coin_valid && (sum <= 8'(MAX_CREDIT));
    assign credit_add = coin_ok ? sum[6:0] : credit_q;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        prod_d   = prod_q;
        amt_d    = amt_q;
        wait_d   = wait_q;
        rej_d    = 1'b0;
`ifdef IDLE_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = credit_add;
                        state_d  = S_COLLECT;
`ifdef IDLE_TIMEOUT_EN
                        idle_d   = '0;
`endif
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                // Same-cycle coin is folded in before cancel/select act.
                rej_d    = coin_valid && !coin_ok;
                credit_d = credit_add;
                if (cancel) begin
                    amt_d   = credit_add;
                    state_d = S_REFUND;
                end else if (sel_valid && sel_prod != 3'd0) begin
                    prod_d  = sel_prod;
                    wait_d  = '0;
                    state_d = S_VEND;
                end
`ifdef IDLE_TIMEOUT_EN
                else if (coin_valid || sel_valid) begin
                    idle_d = '0;
                end else if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                    amt_d   = credit_add;
                    state_d = S_REFUND;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            S_VEND: begin
                rej_d = coin_valid;
                if (sold) begin
                    amt_d   = rem;
                    state_d = S_REFUND;
                end else if (wait_q == WW'(VEND_WAIT - 1)) begin
                    amt_d   = credit_q;
                    state_d = S_REFUND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                rej_d    = coin_valid;
                credit_d = '0;
                prod_d   = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            prod_q   <= '0;
            amt_q    <= '0;
            wait_q   <= '0;
            rej_q    <= 1'b0;
`ifdef IDLE_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            prod_q   <= prod_d;
            amt_q    <= amt_d;
            wait_q   <= wait_d;
            rej_q    <= rej_d;
`ifdef IDLE_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign money        = (state_q == S_VEND) ? credit_q : '0;
    assign prod         = (state_q == S_VEND) ? prod_q : '0;
    assign credit       = credit_q;
    assign coin_reject  = rej_q;
    assign refund_valid = (state_q == S_REFUND) && (amt_q != 7'd0);
    assign refund_amt   = (state_q == S_REFUND) ? amt_q : '0;
    assign busy         = (state_q == S_VEND) || (state_q == S_REFUND);

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: directed vectors with hand-computed expectations for
// coin_collector (MAX_CREDIT=100, VEND_WAIT=16, IDLE_TIMEOUT=8).
module tb_coin_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [2:0] sel_prod;
    logic       cancel;
    logic       sold;
    logic [6:0] rem;
    logic [6:0] money;
    logic [2:0] prod;
    logic [6:0] credit;
    logic       coin_reject;
    logic       refund_valid;
    logic [6:0] refund_amt;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    coin_collector #(
        .MAX_CREDIT  (100),
        .VEND_WAIT   (16),
        .IDLE_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .sel_valid   (sel_valid),
        .sel_prod    (sel_prod),
        .cancel      (cancel),
        .sold        (sold),
        .rem         (rem),
        .money       (money),
        .prod        (prod),
        .credit      (credit),
        .coin_reject (coin_reject),
        .refund_valid(refund_valid),
        .refund_amt  (refund_amt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [2:0] p);
        sel_valid = 1'b1;
        sel_prod  = p;
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        coin_valid = 1'b0;
        coin_type = 2'b00;
        sel_valid = 1'b0;
        sel_prod = 3'd0;
        cancel = 1'b0;
        sold = 1'b0;
        rem = 7'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_money", money, 0);
        chk("rst_prod", prod, 0);
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", refund_valid, 0);
        chk("rst_rej", coin_reject, 0);

        // Basic vend, exact change
        coin(2'b01);
        chk("t1_credit", credit, 10);
        sel(3'd1);
        chk("t1_money", money, 10);
        chk("t1_prod", prod, 1);
        chk("t1_busy", busy, 1);
        sold = 1'b1;
        rem = 7'd0;
        tick();
        sold = 1'b0;
        chk("t1_rv", refund_valid, 0);
        chk("t1_money0", money, 0);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_credit", credit, 0);

        // Saturation at MAX_CREDIT
        coin(2'b11);
        chk("t2_c50", credit, 50);
        coin(2'b11);
        chk("t2_c100", credit, 100);
        coin(2'b00);
        chk("t2_rej", coin_reject, 1);
        chk("t2_c_hold", credit, 100);
        tick();
        chk("t2_rej_pulse", coin_reject, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t2_rv", refund_valid, 1);
        chk("t2_amt", refund_amt, 100);
        tick();
        chk("t2_clr", credit, 0);

        // Vend with change
        coin(2'b01);
        coin(2'b00);
        chk("t3_credit", credit, 15);
        sel(3'd2);
        chk("t3_money", money, 15);
        chk("t3_prod", prod, 2);
        sold = 1'b1;
        rem = 7'd5;
        tick();
        sold = 1'b0;
        rem = 7'd0;
        chk("t3_rv", refund_valid, 1);
        chk("t3_amt", refund_amt, 5);
        tick();
        chk("t3_clr", credit, 0);
        chk("t3_rv_pulse", refund_valid, 0);

        // Vend timeout, coin rejected mid-VEND
        coin(2'b01);
        sel(3'd3);
        for (int i = 0; i < 15; i++) begin
            if (i == 4) coin_valid = 1'b1;
            tick();
            coin_valid = 1'b0;
            if (i == 4) begin
                chk("t4_vend_rej", coin_reject, 1);
                chk("t4_vend_money", money, 10);
            end
        end
        chk("t4_still_vend", busy, 1);
        chk("t4_no_rv_yet", refund_valid, 0);
        chk("t4_money_hold", money, 10);
        tick();
        chk("t4_rv", refund_valid, 1);
        chk("t4_amt", refund_amt, 10);
        chk("t4_money0", money, 0);
        chk("t4_prod0", prod, 0);
        tick();
        chk("t4_idle", busy, 0);

        // cancel beats sel
        coin(2'b10);
        chk("t5_credit", credit, 20);
        cancel = 1'b1;
        sel_valid = 1'b1;
        sel_prod = 3'd4;
        tick();
        cancel = 1'b0;
        sel_valid = 1'b0;
        chk("t5_rv", refund_valid, 1);
        chk("t5_amt", refund_amt, 20);
        chk("t5_money", money, 0);
        chk("t5_prod", prod, 0);
        tick();
        chk("t5_clr", credit, 0);

        // coin + cancel same cycle is refunded too
        coin(2'b00);
        coin_valid = 1'b1;
        coin_type = 2'b01;
        cancel = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel = 1'b0;
        chk("t6_amt", refund_amt, 15);
        tick();

        // coin + sel same cycle: VEND uses updated credit
        coin(2'b00);
        coin_valid = 1'b1;
        coin_type = 2'b01;
        sel_valid = 1'b1;
        sel_prod = 3'd5;
        tick();
        coin_valid = 1'b0;
        sel_valid = 1'b0;
        chk("t7_money", money, 15);
        chk("t7_prod", prod, 5);
        sold = 1'b1;
        tick();
        sold = 1'b0;
        chk("t7_rv", refund_valid, 0);
        tick();

        // sel_prod=0 ignored
        coin(2'b00);
        sel(3'd0);
        chk("t8_busy", busy, 0);
        chk("t8_money", money, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();

        // reset mid-operation drops credit silently
        coin(2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t9_credit", credit, 0);
        chk("t9_rv", refund_valid, 0);

        // inactivity
        coin(2'b00);
        for (int i = 0; i < 7; i++) tick();
        chk("t10_pre_rv", refund_valid, 0);
        tick();
`ifdef IDLE_TIMEOUT_EN
        chk("t10_rv", refund_valid, 1);
        chk("t10_amt", refund_amt, 5);
        tick();
        chk("t10_clr", credit, 0);
`else
        chk("t10_rv", refund_valid, 0);
        chk("t10_credit", credit, 5);
        chk("t10_busy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coin_collector.md
Name: coin_collector

Overview:
- Front-end stage that sits directly upstream of the vend core.
- Accepts coin-insert pulses, accumulates credit and latches the customer's product selection.
- Presents money/prod to the vend core, then waits for its sold/rem response and issues change or a full refund.
- Converts asynchronous-looking customer events into the steady money/prod levels the vend core expects; money is driven 0 whenever no vend is in progress.

Parameters:
- MAX_CREDIT, 100: highest credit accepted; must be ≤127 (7-bit money path).
- VEND_WAIT, 16: cycles to hold a request while awaiting sold before declaring failure.
- IDLE_TIMEOUT, 255: cycles of inactivity in COLLECT before auto-refund (IDLE_TIMEOUT_EN builds only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- coin_valid  in  1  one-cycle coin-insert strobe.
- coin_type  in  2  denomination: 00=5, 01=10, 10=20, 11=50.
- sel_valid  in  1  one-cycle product-select strobe.
- sel_prod  in  3  product code 1..7; 0 is invalid.
- cancel  in  1  one-cycle customer cancel strobe.
- sold  in  1  from vend core: purchase accepted.
- rem  in  7  from vend core: change owed, valid while sold=1.
- money  out  7  to vend core: credit offered.
- prod  out  3  to vend core: product requested.
- credit  out  7  current accumulated credit, for display.
- coin_reject  out  1  one-cycle pulse: last coin refused.
- refund_valid  out  1  one-cycle pulse: pay out refund_amt.
- refund_amt  out  7  amount to return; valid with refund_valid.
- busy  out  1  high in VEND and REFUND.

Behaviour:
- Reset values: all outputs 0, state IDLE, credit 0, latched product 0, counters 0. Reset mid-operation discards credit; no refund is issued.
- IDLE:
  - coin_valid: add value to credit, go to COLLECT.
  - sel_valid and cancel: ignored.
- COLLECT:
  - coin_valid: credit += value when the sum is ≤ MAX_CREDIT. Otherwise credit is unchanged and coin_reject pulses on the next cycle.
  - sel_valid with sel_prod≠0: latch sel_prod, go to VEND next cycle. sel_prod=0 is ignored.
  - cancel: go to REFUND with refund_amt=credit.
- Same-cycle priority in COLLECT:
  - cancel beats sel_valid.
  - A coin arriving in the same cycle as sel_valid is added first; VEND uses the updated credit.
  - A coin arriving in the same cycle as cancel is still added and refunded.
- VEND:
  - money=credit and prod=latched product, held stable every cycle in this state. busy=1.
  - Coins are rejected (coin_reject pulses). sel_valid and cancel are ignored.
  - Wait counter starts at 0 on entry and increments each cycle.
  - sold=1: refund_amt=rem, go to REFUND. rem is sampled in the cycle sold is seen.
  - Counter reaches VEND_WAIT-1 without sold: refund_amt=credit (vend failed), go to REFUND.
- REFUND:
  - money=0, prod=0.
  - One cycle only: refund_valid=1 when refund_amt≠0, otherwise no pulse.
  - credit cleared; return to IDLE next cycle.
  - Coins in this cycle are rejected.
- money and prod are 0 in every state except VEND.
- credit is saturating, never wraps. Exactly MAX_CREDIT is accepted; MAX_CREDIT+1 or more is rejected.
- Latency:
  - coin → credit update: 1 cycle.
  - sel → money/prod valid: 1 cycle.
  - sold → refund_valid: 1 cycle.

Optional Feature:
- IDLE_TIMEOUT_EN defined:
  - COLLECT has an inactivity counter, cleared on any coin_valid or sel_valid.
  - On reaching IDLE_TIMEOUT it forces REFUND with refund_amt=credit.
- Undefined: no counter; COLLECT waits indefinitely.

Test Plan:
- rst=1, 2 cycles → all outputs 0, state IDLE. Coin type 01, then sel_prod=1 → next cycle money=10, prod=1, busy=1. sold=1, rem=0 → no refund_valid, money=0, return to IDLE.
- Coins 50+50 → credit=100. Third coin 5 → coin_reject pulse, credit stays 100.
- credit=15, sel_prod=2; vend core answers sold=1, rem=5 → refund_valid=1, refund_amt=5 one cycle later. credit=0 the cycle after.
- credit=10, sel_prod=3; sold held 0 for VEND_WAIT cycles → refund_valid with refund_amt=10. money/prod return to 0.
- credit=20, cancel and sel_valid in the same cycle → REFUND with refund_amt=20, no VEND. Coin during VEND → coin_reject, money unchanged.
- IDLE_TIMEOUT_EN build, IDLE_TIMEOUT=8: one coin 5, then idle 8 cycles → refund_valid, refund_amt=5. Non-EN build, same stimulus → stays in COLLECT with credit=5.
